// File: rtl/bus_arbiter_rr8.sv
// Round-robin arbiter for the shared 8-input bus mux: grants one owner, drives
// the mux select/enable, bounds each tenure to MaxHold cycles and flags forced releases.
module bus_arbiter_rr8 #(
   parameter int unsigned MaxHold = 16
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] Req,
   input  logic       Done,
   output logic [7:0] Grant,
   output logic [2:0] Sel,
   output logic       Enable,
   output logic       Busy,
   output logic       Timeout
);

   localparam int unsigned N  = 8;
   localparam int unsigned IW = 3;
   localparam int unsigned CW = 8;
   localparam logic [CW-1:0] CntLast = CW'(MaxHold - 1);

   typedef enum logic {IDLE, OWN} state_t;

   state_t        state_q, state_n;
   logic [N-1:0]  grant_q, grant_n;
   logic [IW-1:0] sel_q, sel_n;
   logic [IW-1:0] last_q, last_n;
   logic [CW-1:0] cnt_q, cnt_n;
   logic          busy_q, busy_n;
   logic          enable_q, enable_n;
   logic          timeout_q, timeout_n;

   logic [N-1:0]  owner_oh;
   logic [N-1:0]  others;
   logic [N-1:0]  arb_req;
   logic [IW-1:0] win;
   logic          withdrew;
   logic          at_limit;
   logic          tenure_end;

   // First requester after 'last' in circular order; 'last' itself is checked last.
   function automatic logic [IW-1:0] pick(input logic [N-1:0] r, input logic [IW-1:0] last);
      logic [IW-1:0] w;
      logic          found;
      logic [IW-1:0] idx;
      w     = last;
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
         idx = last + IW'(i);
         if (!found && r[idx]) begin
            w     = idx;
            found = 1'b1;
         end
      end
      return w;
   endfunction

   assign owner_oh   = N'(1) << sel_q;
   assign others     = Req & ~owner_oh;
   assign withdrew   = ~|(Req & owner_oh);
   assign at_limit   = (cnt_q == CntLast);
   assign tenure_end = Done | withdrew | at_limit;
   assign arb_req    = (state_q == OWN) ? others : Req;
   assign win        = pick(arb_req, last_q);

   // Next-state and registered-output decode
   always_comb begin
      state_n   = state_q;
      grant_n   = grant_q;
      sel_n     = sel_q;
      last_n    = last_q;
      cnt_n     = cnt_q;
      busy_n    = busy_q;
      enable_n  = enable_q;
      timeout_n = 1'b0;
      case (state_q)
         IDLE: begin
            if (|Req) begin
               state_n  = OWN;
               grant_n  = N'(1) << win;
               sel_n    = win;
               last_n   = win;
               cnt_n    = '0;
               busy_n   = 1'b1;
               enable_n = 1'b1;
            end
         end
         OWN: begin
            if (tenure_end) begin
               // A forced release only counts when the owner neither finished nor left.
               timeout_n = at_limit & ~Done & ~withdrew;
               cnt_n     = '0;
               if (|others) begin
                  grant_n = N'(1) << win;
                  sel_n   = win;
                  last_n  = win;
               end else begin
                  state_n  = IDLE;
                  grant_n  = '0;
                  busy_n   = 1'b0;
                  enable_n = 1'b0;
               end
            end else begin
               cnt_n = cnt_q + CW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         sel_q     <= '0;
         last_q    <= IW'(N - 1);
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         enable_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_n;
         grant_q   <= grant_n;
         sel_q     <= sel_n;
         last_q    <= last_n;
         cnt_q     <= cnt_n;
         busy_q    <= busy_n;
         enable_q  <= enable_n;
         timeout_q <= timeout_n;
      end
   end

   assign Grant   = grant_q;
   assign Sel     = sel_q;
   assign Enable  = enable_q;
   assign Busy    = busy_q;
   assign Timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_rr8.sv
// Directed bench for bus_arbiter_rr8: a vector table for single-edge behaviour plus
// sequences for async reset, full-load rotation and the MaxHold=1 corner.
module tb_bus_arbiter_rr8;

   logic       clk = 1'b0;
   logic       rst, done, rst1, done1;
   logic [7:0] req, req1;
   logic [7:0] grant, grant1;
   logic [2:0] sel, sel1;
   logic       enable, busy, timeout;
   logic       enable1, busy1, timeout1;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   bus_arbiter_rr8 #(.MaxHold(4)) dut (
      .Clock(clk), .Reset(rst), .Req(req), .Done(done),
      .Grant(grant), .Sel(sel), .Enable(enable), .Busy(busy), .Timeout(timeout)
   );

   bus_arbiter_rr8 #(.MaxHold(1)) dut1 (
      .Clock(clk), .Reset(rst1), .Req(req1), .Done(done1),
      .Grant(grant1), .Sel(sel1), .Enable(enable1), .Busy(busy1), .Timeout(timeout1)
   );

   typedef struct {
      logic [7:0] req;
      logic       done;
      logic [7:0] grant;
      logic [2:0] sel;
      logic       busy;
      logic       to;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic [7:0] r, input logic d, input logic [7:0] g,
                               input logic [2:0] s, input logic b, input logic t);
      vec_t v;
      v.req = r; v.done = d; v.grant = g; v.sel = s; v.busy = b; v.to = t;
      return v;
   endfunction

   task automatic check(input string nm,
                        input logic [7:0] ag, input logic [2:0] as, input logic ab,
                        input logic ae, input logic at,
                        input logic [7:0] g, input logic [2:0] s, input logic b, input logic t);
      n_chk++;
      if ({ag, as, ab, ae, at} === {g, s, b, b, t}) n_pass++;
      else $display("FAIL %s: got grant=%h sel=%0d busy=%b en=%b to=%b, want grant=%h sel=%0d busy=%b en=%b to=%b",
                    nm, ag, as, ab, ae, at, g, s, b, b, t);
   endtask

   initial begin
      logic [2:0] es;
      // Hand-computed single-edge vectors for MaxHold=4, starting from reset (Last=7).
      vq.push_back(mk(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0)); // sole requester 2 granted
      vq.push_back(mk(8'h04, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0)); // Done, nobody else -> idle
      vq.push_back(mk(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0)); // re-grant 2
      vq.push_back(mk(8'h04, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0));
      vq.push_back(mk(8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0)); // idle, Sel holds
      vq.push_back(mk(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0));
      vq.push_back(mk(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0));
      vq.push_back(mk(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0)); // owner 3 withdraws -> 5
      vq.push_back(mk(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0));
      vq.push_back(mk(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0));
      vq.push_back(mk(8'h21, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0)); // counter reaches 3
      vq.push_back(mk(8'h21, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0)); // Done at limit: no timeout
      vq.push_back(mk(8'h03, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0));
      vq.push_back(mk(8'h03, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0));
      vq.push_back(mk(8'h03, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0));
      vq.push_back(mk(8'h03, 1'b0, 8'h02, 3'd1, 1'b1, 1'b1)); // forced hand-over
      vq.push_back(mk(8'h03, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0));
      vq.push_back(mk(8'h0B, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0)); // non-owner change ignored
      vq.push_back(mk(8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0));
      vq.push_back(mk(8'h02, 1'b0, 8'h00, 3'd1, 1'b0, 1'b1)); // sole owner times out -> idle
      vq.push_back(mk(8'h00, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0));

      rst = 1'b1; rst1 = 1'b1; req = '0; req1 = '0; done = 1'b0; done1 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 check("reset", grant, sel, busy, enable, timeout, 8'h00, 3'd0, 1'b0, 1'b0);

      foreach (vq[i]) begin
         @(negedge clk);
         req  = vq[i].req;
         done = vq[i].done;
         @(posedge clk);
         #1 check($sformatf("vec%0d", i), grant, sel, busy, enable, timeout,
                  vq[i].grant, vq[i].sel, vq[i].busy, vq[i].to);
      end

      // Async reset mid-tenure with requester 6 owning, then restart priority from 0.
      @(negedge clk); req = 8'h40; done = 1'b0;
      @(posedge clk);
      #1 check("own6", grant, sel, busy, enable, timeout, 8'h40, 3'd6, 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1 check("async_rst", grant, sel, busy, enable, timeout, 8'h00, 3'd0, 1'b0, 1'b0);
      @(negedge clk); rst = 1'b0; req = 8'hC1;
      @(posedge clk);
      #1 check("post_rst_c1", grant, sel, busy, enable, timeout, 8'h01, 3'd0, 1'b1, 1'b0);

      // All eight requesting: rotation 0..7,0 with 4-cycle tenures and a pulse per switch.
      @(negedge clk); rst = 1'b1; req = 8'h00;
      @(negedge clk); rst = 1'b0; req = 8'hFF;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         es = 3'((k / 4) % 8);
         #1 check($sformatf("rot%0d", k), grant, sel, busy, enable, timeout,
                  8'h01 << es, es, 1'b1, (k > 0) && (k % 4 == 0));
      end

      // MaxHold=1 with requesters 0 and 7: alternation every cycle.
      @(negedge clk); rst1 = 1'b0; req1 = 8'h81;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         es = (k % 2 == 0) ? 3'd0 : 3'd7;
         #1 check($sformatf("mh1_%0d", k), grant1, sel1, busy1, enable1, timeout1,
                  8'h01 << es, es, 1'b1, k > 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
